// File: rtl/otter_lsu.sv
// otter_lsu: load/store unit between the OTTER execute stage and memory data port 2.
// Optional build macro MISALIGN_SPLIT_EN splits misaligned non-MMIO accesses into byte beats.
//
// state   | meaning
// IDLE    | ready for a request
// ISSUE   | drive address/size/sign for the current beat; write strobe or read enable
// CAPTURE | hold address/size/sign while the memory's sized read data is registered
// DONE    | one-cycle response pulse
module otter_lsu #(
    parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
    input  logic        LSU_CLK,
    input  logic        LSU_RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGN,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic        misaligned;
    logic        req_error;

`ifdef MISALIGN_SPLIT_EN
    logic        split_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [1:0]  beat_q;
    logic [1:0]  last_beat_q;
    logic [1:0]  beat_nx;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] acc_q;
    logic [31:0] acc_nx;
    logic [31:0] split_rdata;
    logic [32:0] span_end;
`endif

    always_comb begin
        misaligned = (REQ_SIZE == 2'd1 && REQ_ADDR[1:0] == 2'd3) ||
                     (REQ_SIZE == 2'd2 && REQ_ADDR[1:0] != 2'd0);
`ifdef MISALIGN_SPLIT_EN
        // a split may not start in, or run into, the MMIO region
        span_end  = {1'b0, REQ_ADDR} + ((REQ_SIZE == 2'd2) ? 33'd3 : 33'd1);
        req_error = (REQ_SIZE == 2'd3) ||
                    (misaligned && (REQ_ADDR >= MMIO_BASE || span_end >= {1'b0, MMIO_BASE}));
`else
        req_error = (REQ_SIZE == 2'd3) || misaligned;
`endif
    end

`ifdef MISALIGN_SPLIT_EN
    always_comb begin
        beat_nx = beat_q + 2'd1;
        acc_nx  = acc_q;
        acc_nx[{beat_q, 3'b000} +: 8] = MEM_DOUT2[7:0];
        if (size_q == 2'd1)
            split_rdata = {{16{~sign_q & acc_nx[15]}}, acc_nx[15:0]};
        else
            split_rdata = acc_nx;
    end
`endif

    always_ff @(posedge LSU_CLK or negedge LSU_RST_N) begin
        if (!LSU_RST_N) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            REQ_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= 32'h0;
            RSP_ERR   <= 1'b0;
            MEM_RDEN2 <= 1'b0;
            MEM_WE2   <= 1'b0;
            MEM_ADDR2 <= 32'h0;
            MEM_DIN2  <= 32'h0;
            MEM_SIZE  <= 2'd0;
            MEM_SIGN  <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            sign_q      <= 1'b0;
            size_q      <= 2'd0;
            beat_q      <= 2'd0;
            last_beat_q <= 2'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            acc_q       <= 32'h0;
`endif
        end else begin
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            RSP_RDATA <= 32'h0;
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        REQ_READY <= 1'b0;
                        we_q      <= REQ_WE;
                        if (req_error) begin
                            state     <= DONE;
                            RSP_VALID <= 1'b1;
                            RSP_ERR   <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            MEM_ADDR2 <= REQ_ADDR;
                            MEM_WE2   <= REQ_WE;
                            MEM_RDEN2 <= ~REQ_WE;
`ifdef MISALIGN_SPLIT_EN
                            split_q     <= misaligned;
                            sign_q      <= REQ_SIGN;
                            size_q      <= REQ_SIZE;
                            addr_q      <= REQ_ADDR;
                            wdata_q     <= REQ_WDATA;
                            beat_q      <= 2'd0;
                            acc_q       <= 32'h0;
                            last_beat_q <= (REQ_SIZE == 2'd2) ? 2'd3 : 2'd1;
                            if (misaligned) begin
                                MEM_SIZE <= 2'd0;
                                MEM_SIGN <= 1'b1;
                                MEM_DIN2 <= {24'h0, REQ_WDATA[7:0]};
                            end else begin
                                MEM_SIZE <= REQ_SIZE;
                                MEM_SIGN <= REQ_SIGN;
                                MEM_DIN2 <= REQ_WDATA;
                            end
`else
                            MEM_SIZE <= REQ_SIZE;
                            MEM_SIGN <= REQ_SIGN;
                            MEM_DIN2 <= REQ_WDATA;
`endif
                        end
                    end
                end
                ISSUE: begin
                    MEM_WE2   <= 1'b0;
                    MEM_RDEN2 <= 1'b0;
                    if (!we_q) begin
                        state <= CAPTURE;
                    end else begin
                        state     <= DONE;
                        RSP_VALID <= 1'b1;
`ifdef MISALIGN_SPLIT_EN
                        // store beats run back to back; each ISSUE cycle is one byte write
                        if (split_q && beat_q != last_beat_q) begin
                            state     <= ISSUE;
                            RSP_VALID <= 1'b0;
                            beat_q    <= beat_nx;
                            MEM_WE2   <= 1'b1;
                            MEM_ADDR2 <= addr_q + {30'h0, beat_nx};
                            MEM_DIN2  <= {24'h0, wdata_q[{beat_nx, 3'b000} +: 8]};
                        end
`endif
                    end
                end
                CAPTURE: begin
                    state     <= DONE;
                    RSP_VALID <= 1'b1;
                    RSP_RDATA <= MEM_DOUT2;
`ifdef MISALIGN_SPLIT_EN
                    if (split_q) begin
                        acc_q     <= acc_nx;
                        RSP_RDATA <= split_rdata;
                        if (beat_q != last_beat_q) begin
                            state     <= ISSUE;
                            RSP_VALID <= 1'b0;
                            RSP_RDATA <= 32'h0;
                            beat_q    <= beat_nx;
                            MEM_RDEN2 <= 1'b1;
                            MEM_ADDR2 <= addr_q + {30'h0, beat_nx};
                        end
                    end
`endif
                end
                DONE: begin
                    state     <= IDLE;
                    REQ_READY <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_lsu.sv
// Testbench for otter_lsu: byte-array memory model on port 2, directed and random requests
// checked against a byte-level reference of load/store semantics.
module tb_otter_lsu;

    localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

    logic        lsu_clk = 1'b0;
    logic        lsu_rst_n;
    logic        req_valid, req_ready, req_we, req_sign;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_rden2, mem_we2, mem_sign;
    logic [31:0] mem_addr2, mem_din2, mem_dout2;
    logic [1:0]  mem_size;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tb_mem  [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] rd_word = 32'h0;
    logic [7:0]  dout_b;
    logic [15:0] dout_h;

    always #5 lsu_clk = ~lsu_clk;

    otter_lsu #(.MMIO_BASE(MMIO_BASE)) dut (
        .LSU_CLK(lsu_clk), .LSU_RST_N(lsu_rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_SIZE(req_size), .REQ_SIGN(req_sign),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
        .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2), .MEM_ADDR2(mem_addr2), .MEM_DIN2(mem_din2),
        .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign), .MEM_DOUT2(mem_dout2)
    );

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return tb_mem.exists(a) ? tb_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // memory: registered word read, sized combinationally from the current address/size/sign
    always @(posedge lsu_clk) begin
        if (mem_we2) begin
            for (int i = 0; i < ((mem_size == 2'd0) ? 1 : (mem_size == 2'd1) ? 2 : 4); i++)
                tb_mem[mem_addr2 + i] = mem_din2[8*i +: 8];
        end
        if (mem_rden2) begin
            for (int i = 0; i < 4; i++)
                rd_word[8*i +: 8] <= mem_rd({mem_addr2[31:2], 2'b00} + i);
        end
    end

    always_comb begin
        dout_b    = rd_word[{mem_addr2[1:0], 3'b000} +: 8];
        dout_h    = (mem_addr2[1:0] == 2'd3) ? 16'h0 : rd_word[{mem_addr2[1:0], 3'b000} +: 16];
        mem_dout2 = rd_word;
        if (mem_size == 2'd0)
            mem_dout2 = mem_sign ? {24'h0, dout_b} : {{24{dout_b[7]}}, dout_b};
        else if (mem_size == 2'd1)
            mem_dout2 = mem_sign ? {16'h0, dout_h} : {{16{dout_h[15]}}, dout_h};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        tb_mem[a]  = d;
        ref_mem[a] = d;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sign,
                          output logic [31:0] rdata_o, output logic err_o);
        int n, lat_e, wes_e, rdens_e, lat, wes, rdens;
        bit mis, err_e, prev_rden;
        logic [31:0] rd_e, prev_addr, mem_bytes, ref_bytes;
        longint last;
        n    = (size == 2'd2) ? 4 : (size == 2'd1) ? 2 : 1;
        mis  = (size == 2'd1 && addr[1:0] == 2'd3) || (size == 2'd2 && addr[1:0] != 2'd0);
        last = longint'(addr) + n - 1;
        err_e = (size == 2'd3);
        if (mis) begin
`ifdef MISALIGN_SPLIT_EN
            err_e = (last >= longint'(MMIO_BASE));
`else
            err_e = 1'b1;
`endif
        end
        lat_e   = err_e ? 1 : (!mis ? (we ? 2 : 3) : (we ? n + 1 : 2 * n + 1));
        wes_e   = (err_e || !we) ? 0 : (mis ? n : 1);
        rdens_e = (err_e || we) ? 0 : (mis ? n : 1);
        rd_e = 32'h0;
        if (!err_e && !we) begin
            for (int i = 0; i < n; i++) rd_e[8*i +: 8] = ref_rd(addr + i);
            if (n == 1 && !sign) rd_e = {{24{rd_e[7]}}, rd_e[7:0]};
            if (n == 2 && !sign) rd_e = {{16{rd_e[15]}}, rd_e[15:0]};
        end

        for (int i = 0; i < 20 && !req_ready; i++) @(negedge lsu_clk);
        check("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_sign = sign;
        @(posedge lsu_clk);
        #1;
        req_valid = 1'b0; req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_sign = $urandom;

        lat = 0; wes = 0; rdens = 0; prev_rden = 1'b0; prev_addr = 32'h0;
        rdata_o = 32'h0; err_o = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge lsu_clk);
            if (prev_rden) check("capture_addr_hold", mem_addr2, prev_addr);
            prev_rden = mem_rden2;
            prev_addr = mem_addr2;
            if (mem_we2) begin
                check("store_addr", mem_addr2, addr + (mis ? wes : 0));
                check("store_din", mem_din2,
                      mis ? {24'h0, (wes < 4) ? wdata[8*wes +: 8] : 8'h00} : wdata);
                check("store_size", {30'h0, mem_size}, mis ? 32'd0 : {30'h0, size});
                wes++;
            end
            if (mem_rden2) begin
                check("load_addr", mem_addr2, addr + (mis ? rdens : 0));
                check("load_size_sign", {29'h0, mem_size, mem_sign},
                      mis ? 32'd1 : {29'h0, size, sign});
                rdens++;
            end
            if (rsp_valid) begin
                lat = k; rdata_o = rsp_rdata; err_o = rsp_err;
                break;
            end
        end
        check("rsp_err", err_o, err_e);
        check("rsp_rdata", rdata_o, rd_e);
        check("latency", lat, lat_e);
        check("we_strobes", wes, wes_e);
        check("rden_strobes", rdens, rdens_e);
        @(negedge lsu_clk);
        check("rsp_single_pulse", {30'h0, rsp_valid, req_ready}, 32'd1);

        if (we && !err_e) begin
            mem_bytes = 32'h0; ref_bytes = 32'h0;
            for (int i = 0; i < n; i++) begin
                ref_mem[addr + i]   = wdata[8*i +: 8];
                ref_bytes[8*i +: 8] = wdata[8*i +: 8];
                mem_bytes[8*i +: 8] = mem_rd(addr + i);
            end
            check("mem_contents", mem_bytes, ref_bytes);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        lsu_rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'd0; req_sign = 1'b0;
        preload(32'h200, 8'h34); preload(32'h201, 8'h12);
        preload(32'h202, 8'hFF); preload(32'h203, 8'h80);
        preload(32'h107, 8'hFE); preload(32'h108, 8'h81);

        repeat (2) @(negedge lsu_clk);
        check("reset_ready", req_ready, 1'b1);
        check("reset_rsp", {29'h0, rsp_valid, rsp_err, mem_sign}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_strobes", {28'h0, mem_we2, mem_rden2, mem_size}, 32'd0);
        check("reset_mem_addr", mem_addr2, 32'h0);
        check("reset_mem_din", mem_din2, 32'h0);
        lsu_rst_n = 1'b1;
        @(negedge lsu_clk);

        do_req(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, rd, er);
        do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, rd, er);
        check("aligned_load_word", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h203, 32'h0, 2'd0, 1'b0, rd, er);
        check("signed_byte_load", rd, 32'hFFFF_FF80);

        do_req(1'b1, 32'h102, 32'h1122_3344, 2'd2, 1'b0, rd, er);
        do_req(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, rd, er);
`ifdef MISALIGN_SPLIT_EN
        check("split_word_load", rd, 32'h1122_3344);
`else
        check("split_word_load_err", {rd[30:0], er}, 32'd1);
`endif
        do_req(1'b0, 32'h107, 32'h0, 2'd1, 1'b0, rd, er);
`ifdef MISALIGN_SPLIT_EN
        check("split_half_load", rd, 32'hFFFF_81FE);
`else
        check("split_half_load_err", {rd[30:0], er}, 32'd1);
`endif

        do_req(1'b0, 32'h104, 32'h0, 2'd3, 1'b0, rd, er);
        check("size3_err", {rd[30:0], er}, 32'd1);
        do_req(1'b1, MMIO_BASE - 32'd2, 32'hCAFE_F00D, 2'd2, 1'b0, rd, er);
        check("mmio_cross_err", {rd[30:0], er}, 32'd1);
        do_req(1'b1, 32'h0001_0004, 32'hA5A5_5A5A, 2'd2, 1'b0, rd, er);
        do_req(1'b0, 32'h0001_0004, 32'h0, 2'd2, 1'b0, rd, er);
        check("mmio_aligned_passthru", rd, 32'hA5A5_5A5A);

        // reset in the middle of a read: second CAPTURE for a split load, first for an aligned one
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sign = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        req_addr = 32'h102;
`else
        req_addr = 32'h200;
`endif
        @(posedge lsu_clk);
        #1 req_valid = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        repeat (4) @(negedge lsu_clk);
`else
        repeat (2) @(negedge lsu_clk);
`endif
        lsu_rst_n = 1'b0;
        #1;
        check("midreset_ready", req_ready, 1'b1);
        check("midreset_outputs", {28'h0, rsp_valid, rsp_err, mem_we2, mem_rden2}, 32'd0);
        check("midreset_mem_addr", mem_addr2, 32'h0);
        check("midreset_rdata", rsp_rdata, 32'h0);
        @(negedge lsu_clk);
        lsu_rst_n = 1'b1;
        @(negedge lsu_clk);
        check("post_reset_ready", {31'h0, req_ready}, 32'd1);

        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            logic [1:0]  s;
            a = ($urandom_range(0, 4) == 0) ? (MMIO_BASE - 32'd4 + $urandom_range(0, 11))
                                            : (32'h100 + $urandom_range(0, 63));
            s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(1'($urandom), a, $urandom, s, 1'($urandom), rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
